// File: rtl/ipgu_pyramid.sv
// ipgu_pyramid: image-pyramid window generator.
// Walks every enabled level of a programmable level table. Each level is cut into
// nwin x nwin windows of WIN x WIN pixels, and each pixel is fetched from a square
// source image through a 1-cycle-latency read port using nearest-neighbour Q8.8 scaling.
// Fetched pixels are queued in a 2-entry FIFO together with level/window sideband and
// streamed out over a valid/ready handshake.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, abort       begin a pass (from IDLE) / flush back to IDLE
//   busy, done         pass in progress / 1-cycle end-of-pass pulse
//   cfg_we/idx/nwin/step  level-table write port (only while idle)
//   mem_rd_en/addr/rd_data  source image read port (data the cycle after rd_en)
//   out_valid/ready/data/last/level/wx/wy  output beat stream with sideband
module ipgu_pyramid #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_DIM    = 300,
  parameter int unsigned WIN        = 20,
  parameter int unsigned NUM_LEVELS = 8,
  localparam int unsigned ADDR_W    = $clog2(IMG_DIM * IMG_DIM),
  localparam int unsigned LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int unsigned NWIN_W    = $clog2(IMG_DIM / WIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              cfg_we,
  input  logic [LVL_W-1:0]  cfg_idx,
  input  logic [NWIN_W-1:0] cfg_nwin,
  input  logic [15:0]       cfg_step,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [LVL_W-1:0]  out_level,
  output logic [NWIN_W-1:0] out_wx,
  output logic [NWIN_W-1:0] out_wy
);

  localparam int unsigned PIX_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned CRD_W  = $clog2(IMG_DIM);
  localparam int unsigned PROD_W = 48;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} stateT;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LVL_W-1:0]  level;
    logic [NWIN_W-1:0] wx;
    logic [NWIN_W-1:0] wy;
    logic              last;
  } beatT;

  stateT             state;
  logic [NWIN_W-1:0] nwinTab [NUM_LEVELS];
  logic [15:0]       stepTab [NUM_LEVELS];

  // Position of the next pixel to fetch and its precomputed source address
  logic [LVL_W-1:0]  lvl;
  logic [NWIN_W-1:0] wx, wy;
  logic [PIX_W-1:0]  px, py;
  logic [ADDR_W-1:0] addrReg;

  // Sideband of the read whose data is on mem_rd_data this cycle
  logic              rdValid;
  logic [LVL_W-1:0]  sbLevel;
  logic [NWIN_W-1:0] sbWx, sbWy;
  logic              sbLast;

  beatT              fifo [2];
  logic              rdPtr, wrPtr;
  logic [1:0]        fifoCnt;

  logic [LVL_W-1:0]  firstLvl, nextLvl, nLvl;
  logic              anyEn, nextFound, endOfPass, pixLast;
  logic [NWIN_W-1:0] nwinM1, nWx, nWy;
  logic [PIX_W-1:0]  nPx, nPy;
  logic [ADDR_W-1:0] nAddr;
  logic [2:0]        occ;
  logic              pop, rdGo;

  // Nearest-neighbour source coordinate, clamped to the image edge
  function automatic logic [CRD_W-1:0] srcCoord(input logic [NWIN_W-1:0] w,
                                                input logic [PIX_W-1:0] p,
                                                input logic [15:0] step);
    logic [PROD_W-1:0] dst;
    logic [PROD_W-1:0] prod;
    dst  = PROD_W'(w) * PROD_W'(WIN) + PROD_W'(p);
    prod = (dst * PROD_W'(step)) >> 8;
    if (prod > PROD_W'(IMG_DIM - 1)) prod = PROD_W'(IMG_DIM - 1);
    return CRD_W'(prod);
  endfunction

  assign pop       = out_valid & out_ready;
  // Credit includes this cycle's pop so a steady stream sustains one read per cycle
  assign occ       = 3'(fifoCnt) + 3'(rdValid) - 3'(pop);
  assign rdGo      = (state == SCAN) && (occ < 3'd2);
  assign mem_rd_en = rdGo;
  assign mem_addr  = addrReg;

  assign out_valid = (fifoCnt != 2'd0);
  assign out_data  = fifo[rdPtr].data;
  assign out_level = fifo[rdPtr].level;
  assign out_wx    = fifo[rdPtr].wx;
  assign out_wy    = fifo[rdPtr].wy;
  assign out_last  = out_valid & fifo[rdPtr].last;

  // Level search and next-position/address computation
  always_comb begin
    firstLvl  = '0;
    anyEn     = 1'b0;
    nextLvl   = '0;
    nextFound = 1'b0;
    for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
      if (nwinTab[i] != '0) begin
        firstLvl = LVL_W'(i);
        anyEn    = 1'b1;
        if (i > int'(lvl)) begin
          nextLvl   = LVL_W'(i);
          nextFound = 1'b1;
        end
      end
    end

    nwinM1    = nwinTab[lvl] - NWIN_W'(1);
    pixLast   = (px == PIX_W'(WIN - 1)) && (py == PIX_W'(WIN - 1));
    nLvl      = lvl;
    nWy       = wy;
    nWx       = wx;
    nPy       = py;
    nPx       = px;
    endOfPass = 1'b0;
    if (px != PIX_W'(WIN - 1)) begin
      nPx = px + PIX_W'(1);
    end else begin
      nPx = '0;
      if (py != PIX_W'(WIN - 1)) begin
        nPy = py + PIX_W'(1);
      end else begin
        nPy = '0;
        if (wx != nwinM1) begin
          nWx = wx + NWIN_W'(1);
        end else begin
          nWx = '0;
          if (wy != nwinM1) begin
            nWy = wy + NWIN_W'(1);
          end else begin
            nWy = '0;
            if (nextFound) nLvl = nextLvl;
            else endOfPass = 1'b1;
          end
        end
      end
    end
    nAddr = ADDR_W'(srcCoord(nWy, nPy, stepTab[nLvl])) * ADDR_W'(IMG_DIM)
          + ADDR_W'(srcCoord(nWx, nPx, stepTab[nLvl]));
  end

  // Control FSM, scan counters and level table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      lvl     <= '0;
      wy      <= '0;
      wx      <= '0;
      py      <= '0;
      px      <= '0;
      addrReg <= '0;
      for (int i = 0; i < int'(NUM_LEVELS); i++) begin
        nwinTab[i] <= '0;
        stepTab[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (cfg_we && !busy) begin
        nwinTab[cfg_idx] <= cfg_nwin;
        stepTab[cfg_idx] <= cfg_step;
      end
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            busy    <= 1'b1;
            lvl     <= firstLvl;
            wy      <= '0;
            wx      <= '0;
            py      <= '0;
            px      <= '0;
            addrReg <= '0;   // origin pixel always maps to source address 0
            state   <= anyEn ? SCAN : DRAIN;
          end
          SCAN: if (rdGo) begin
            lvl     <= nLvl;
            wy      <= nWy;
            wx      <= nWx;
            py      <= nPy;
            px      <= nPx;
            addrReg <= nAddr;
            if (endOfPass) state <= DRAIN;
          end
          DRAIN: if (!rdValid && (fifoCnt == 2'd0 || (fifoCnt == 2'd1 && pop))) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read sideband pipeline and 2-entry output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid <= 1'b0;
      sbLevel <= '0;
      sbWx    <= '0;
      sbWy    <= '0;
      sbLast  <= 1'b0;
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      fifoCnt <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else if (abort) begin
      rdValid <= 1'b0;
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      fifoCnt <= '0;
    end else begin
      rdValid <= rdGo;
      if (rdGo) begin
        sbLevel <= lvl;
        sbWx    <= wx;
        sbWy    <= wy;
        sbLast  <= pixLast;
      end
      if (rdValid) begin
        fifo[wrPtr] <= '{data: mem_rd_data, level: sbLevel, wx: sbWx, wy: sbWy, last: sbLast};
        wrPtr       <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + 2'(rdValid) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ipgu_pyramid.sv
// Directed bench for ipgu_pyramid with an 8x8 source image holding src[a]=a,
// 4x4 windows and a 2-entry level table.
module tb_ipgu_pyramid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_idx = '0;
  logic [1:0]  cfg_nwin = '0;
  logic [15:0] cfg_step = '0;
  logic        busy, done, mem_rd_en;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [0:0]  out_level;
  logic [1:0]  out_wx, out_wy;

  int checks = 0;
  int failures = 0;

  ipgu_pyramid #(.DATA_W(8), .IMG_DIM(8), .WIN(4), .NUM_LEVELS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_nwin(cfg_nwin), .cfg_step(cfg_step),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_level(out_level), .out_wx(out_wx), .out_wy(out_wy)
  );

  always #5 clk = ~clk;

  // Source image: each location holds its own address
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'(mem_addr);

  wire [13:0] curBeat = {out_level, out_wx, out_wy, out_last, out_data};

  // Handshake monitors: held-beat stability, outstanding reads, read count
  int   readCnt = 0;
  int   outs = 0;
  int   maxOuts = 0;
  int   stableErr = 0;
  int   stallCnt = 0;
  bit   stallPrev = 1'b0;
  logic [13:0] held = '0;
  always @(posedge clk) begin
    if (mem_rd_en) readCnt = readCnt + 1;
    if (rst || abort) outs = 0;
    else outs = outs + int'(mem_rd_en) - int'(out_valid && out_ready);
    if (outs > maxOuts) maxOuts = outs;
    if (stallPrev && curBeat != held) stableErr = stableErr + 1;
    stallPrev = out_valid && !out_ready && !abort && !rst;
    if (stallPrev) stallCnt = stallCnt + 1;
    held = curBeat;
  end

  int shN [2] = '{0, 0};
  int shS [2] = '{0, 0};
  logic [13:0] expQ [$];
  logic [13:0] obsQ [$];
  int firstValid, doneCyc, lastBeat, readsPass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(input int l, input int wx, input int wy, input int last, input int data);
    return {1'(l), 2'(wx), 2'(wy), 1'(last), 8'(data)};
  endfunction

  task automatic writeCfg(input int idx, input int nwin, input int step);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 1'(idx); cfg_nwin = 2'(nwin); cfg_step = 16'(step);
    @(negedge clk);
    cfg_we = 1'b0;
    shN[idx] = nwin; shS[idx] = step;
  endtask

  // Expected beat stream: level, wy, wx, py, px nested loops over the shadow table
  task automatic buildExp();
    int dx, dy, sx, sy;
    expQ.delete();
    for (int l = 0; l < 2; l++)
      for (int wy = 0; wy < shN[l]; wy++)
        for (int wx = 0; wx < shN[l]; wx++)
          for (int py = 0; py < 4; py++)
            for (int px = 0; px < 4; px++) begin
              dx = wx * 4 + px; dy = wy * 4 + py;
              sx = (dx * shS[l]) >> 8; sy = (dy * shS[l]) >> 8;
              if (sx > 7) sx = 7;
              if (sy > 7) sy = 7;
              expQ.push_back(mk(l, wx, wy, (px == 3 && py == 3) ? 1 : 0, sy * 8 + sx));
            end
  endtask

  task automatic cmpSeq(input string tag);
    chk({tag, "_nbeats"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
  endtask

  // One pass: start, then per cycle (cycle 0 = first cycle after start is sampled)
  // pick out_ready, record accepted beats, note first valid and done.
  task automatic runPass(input bit rndReady, input int abortAt, input bit poke);
    int k, rs;
    obsQ.delete();
    firstValid = -1; doneCyc = -1; lastBeat = -1;
    rs = readCnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (k < 3000 && doneCyc < 0) begin
      if (done) doneCyc = k;
      if (out_valid && firstValid < 0) firstValid = k;
      if (abortAt >= 0 && obsQ.size() == abortAt) begin
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        for (int j = 0; j < 6; j++) begin
          if (done) doneCyc = k + j;
          @(negedge clk);
        end
        break;
      end
      out_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_we = poke && (k == 20);
      start  = poke && (k == 20);
      if (out_valid && out_ready) begin
        obsQ.push_back(curBeat);
        lastBeat = k;
      end
      @(negedge clk);
      k++;
    end
    cfg_we = 1'b0; start = 1'b0; out_ready = 1'b0;
    readsPass = readCnt - rs;
    if (abortAt < 0) chk("pass_done_seen", 32'(doneCyc >= 0), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    rst = 1'b0;

    // Single level at unit scale; mid-pass cfg write and start must be ignored
    writeCfg(0, 2, 16'h100);
    cfg_idx = 1'b1; cfg_nwin = 2'd1; cfg_step = 16'h200;
    buildExp();
    runPass(1'b0, -1, 1'b1);
    cmpSeq("t1");
    chk("t1_first_valid", 32'(firstValid), 2);
    chk("t1_done_cyc", 32'(doneCyc), 66);
    chk("t1_done_after_last", 32'(doneCyc - lastBeat), 1);
    chk("t1_reads", 32'(readsPass), 64);
    chk("t1_b4", 32'(obsQ[4]), 32'(mk(0, 0, 0, 0, 8)));
    chk("t1_b14_last", 32'(obsQ[14][8]), 0);
    chk("t1_b15", 32'(obsQ[15]), 32'(mk(0, 0, 0, 1, 27)));
    chk("t1_b16", 32'(obsQ[16]), 32'(mk(0, 1, 0, 0, 4)));

    // Second level at half scale
    writeCfg(1, 1, 16'h200);
    buildExp();
    runPass(1'b0, -1, 1'b0);
    cmpSeq("t2");
    chk("t2_done_cyc", 32'(doneCyc), 82);
    chk("t2_b64", 32'(obsQ[64]), 32'(mk(1, 0, 0, 0, 0)));
    chk("t2_b68", 32'(obsQ[68]), 32'(mk(1, 0, 0, 0, 16)));
    chk("t2_b79", 32'(obsQ[79]), 32'(mk(1, 0, 0, 1, 54)));

    // Random backpressure
    writeCfg(1, 0, 0);
    buildExp();
    runPass(1'b1, -1, 1'b0);
    cmpSeq("t3");
    chk("t3_stable", 32'(stableErr), 0);
    chk("t3_outstanding_le2", 32'(maxOuts <= 2), 1);
    chk("t3_stalls_seen", 32'(stallCnt > 0), 1);

    // Coordinate overflow clamps to the image edge
    writeCfg(0, 2, 16'h300);
    buildExp();
    runPass(1'b0, -1, 1'b0);
    cmpSeq("t4");
    chk("t4_b3", 32'(obsQ[3]), 32'(mk(0, 0, 0, 0, 7)));
    chk("t4_b63", 32'(obsQ[63]), 32'(mk(0, 1, 1, 1, 63)));

    // Abort at beat 10, abort beating start, then a clean replay
    writeCfg(0, 2, 16'h100);
    buildExp();
    runPass(1'b0, 10, 1'b0);
    chk("t5_beats_before_abort", 32'(obsQ.size()), 10);
    chk("t5_no_done", 32'(doneCyc), 32'(-1));
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("t5_abort_wins", 32'(busy), 0);
    runPass(1'b0, -1, 1'b0);
    cmpSeq("t5_replay");

    // Reset mid-pass clears everything, including the level table
    @(negedge clk); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_rd_en", 32'(mem_rd_en), 0);
    @(negedge clk); rst = 1'b0;
    shN = '{0, 0}; shS = '{0, 0};
    buildExp();
    runPass(1'b0, -1, 1'b0);
    chk("t6_done_cyc", 32'(doneCyc), 1);
    chk("t6_reads", 32'(readsPass), 0);
    chk("t6_beats", 32'(obsQ.size()), 0);
    chk("t6_no_valid", 32'(firstValid), 32'(-1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
